// File: rtl/calendar_pkg.sv
// Calendar field layout, reset date, calendar helper functions and the
// serial weekday calculator state encoding.
package calendar_pkg;

  localparam int CAL_YEAR_W = 14;
  localparam int DAY_W      = 5;
  localparam int MONTH_W    = 4;
  localparam int DAY_LSB    = 0;
  localparam int MONTH_LSB  = DAY_LSB + DAY_W;
  localparam int YEAR_LSB   = MONTH_LSB + MONTH_W;

  // 0001-01-01, a Monday
  localparam logic [CAL_YEAR_W+8:0] RESET_DATE = 23'h000221;

  typedef enum logic [1:0] {IDLE, DIV, SUM, MOD} calc_state_e;

  function automatic logic is_leap(input logic [31:0] y);
    return ((y % 32'd4) == 32'd0) &&
           (((y % 32'd100) != 32'd0) || ((y % 32'd400) == 32'd0));
  endfunction

  function automatic logic [4:0] month_len(input logic [3:0] m, input logic leap);
    case (m)
      4'd2:                      return leap ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   return 5'd30;
      default:                   return 5'd31;
    endcase
  endfunction

  // Days in the year before the first of month m.
  function automatic logic [8:0] month_offset(input logic [3:0] m, input logic leap);
    logic [8:0] off;
    case (m)
      4'd2:    off = 9'd31;
      4'd3:    off = 9'd59;
      4'd4:    off = 9'd90;
      4'd5:    off = 9'd120;
      4'd6:    off = 9'd151;
      4'd7:    off = 9'd181;
      4'd8:    off = 9'd212;
      4'd9:    off = 9'd243;
      4'd10:   off = 9'd273;
      4'd11:   off = 9'd304;
      4'd12:   off = 9'd334;
      default: off = 9'd0;
    endcase
    if (leap && (m > 4'd2)) off = off + 9'd1;
    return off;
  endfunction

endpackage

// File: rtl/weekday_calc_serial.sv
// Serial weekday of an absolute date: divide (Y-1) by 100, form the day
// count, then reduce it mod 7 one bit per cycle.
module weekday_calc_serial
  import calendar_pkg::*;
#(
  parameter int YEAR_W  = CAL_YEAR_W,
  parameter int SUM_W   = YEAR_W + 9,
  parameter int LATENCY = YEAR_W + SUM_W + 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [YEAR_W-1:0] year_i,
  input  logic [3:0]        month_i,
  input  logic [4:0]        day_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [2:0]        wday_o
);

  localparam int CNT_W = $clog2(LATENCY);

  calc_state_e       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [YEAR_W-1:0] ym1_q, dq_q;
  logic [6:0]        rem_q;
  logic [3:0]        month_q;
  logic [4:0]        day_q;
  logic              leap_q;
  logic [SUM_W-1:0]  sum_q;
  logic [2:0]        r_q;

  logic [7:0]        div_t;
  logic              qbit;
  logic [6:0]        rem_n;
  logic [3:0]        mod_t;
  logic [2:0]        mod_n;
  logic [SUM_W-1:0]  sum_n;

  // Restoring divide step by 100; dq_q shifts the dividend out and the quotient in.
  assign div_t = {rem_q, dq_q[YEAR_W-1]};
  assign qbit  = (div_t >= 8'd100);
  assign rem_n = qbit ? 7'(div_t - 8'd100) : div_t[6:0];

  assign mod_t = {r_q, sum_q[SUM_W-1]};
  assign mod_n = (mod_t >= 4'd7) ? 3'(mod_t - 4'd7) : mod_t[2:0];

  // dq_q holds q100 once DIV has finished.
  assign sum_n = SUM_W'(ym1_q) + SUM_W'(ym1_q >> 2) - SUM_W'(dq_q) + SUM_W'(dq_q >> 2)
               + SUM_W'(month_offset(month_q, leap_q)) + SUM_W'(day_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_o  = 1'b0;
    if (start_i) begin
      state_d = DIV;
      cnt_d   = CNT_W'(YEAR_W - 1);
    end else begin
      case (state_q)
        DIV: begin
          if (cnt_q == '0) state_d = SUM;
          else             cnt_d   = cnt_q - CNT_W'(1);
        end
        SUM: begin
          state_d = MOD;
          cnt_d   = CNT_W'(SUM_W);
        end
        MOD: begin
          if (cnt_q == '0) begin
            done_o  = 1'b1;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (start_i) begin
      ym1_q   <= year_i - YEAR_W'(1);
      dq_q    <= year_i - YEAR_W'(1);
      rem_q   <= '0;
      month_q <= month_i;
      day_q   <= day_i;
      leap_q  <= is_leap(32'(year_i));
    end else begin
      case (state_q)
        DIV: begin
          dq_q  <= {dq_q[YEAR_W-2:0], qbit};
          rem_q <= rem_n;
        end
        SUM: begin
          sum_q <= sum_n;
          r_q   <= '0;
        end
        MOD: begin
          if (cnt_q != '0) begin
            r_q   <= mod_n;
            sum_q <= {sum_q[SUM_W-2:0], 1'b0};
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o = (state_q != IDLE);
  assign wday_o = r_q;

endmodule

// File: rtl/date_step_controller.sv
// Current calendar date and weekday: absolute loads through the serial
// weekday calculator, single-day steps and free-run ticking.
module date_step_controller
  import calendar_pkg::*;
#(
  parameter int YEAR_W  = CAL_YEAR_W,
  parameter int SUM_W   = YEAR_W + 9,
  parameter int LATENCY = YEAR_W + SUM_W + 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [YEAR_W+8:0]   load_date,
  input  logic                step_fwd,
  input  logic                step_bwd,
  input  logic                run_en,
  input  logic                tick,
  output logic [YEAR_W+8:0]   date,
  output logic [2:0]          weekday,
  output logic                valid,
  output logic                busy,
  output logic                err
);

  localparam int DATE_W = YEAR_W + 9;
  localparam logic [DATE_W-1:0] RST_DATE = DATE_W'(RESET_DATE);
  localparam logic [YEAR_W-1:0] YEAR_MAX = '1;

  logic [DATE_W-1:0] date_q, date_d, pend_q, pend_d;
  logic [2:0]        wday_q, wday_d;
  logic              err_q, err_d;

  logic [YEAR_W-1:0] cur_y, ld_y;
  logic [3:0]        cur_m, ld_m;
  logic [4:0]        cur_d, ld_d;
  logic              cur_leap, ld_leap;
  logic [4:0]        cur_mlen, prev_mlen;
  logic              at_max, at_min;
  logic              load_ok, start, fwd;
  logic              calc_busy, calc_done;
  logic [2:0]        calc_wday;

  assign {cur_y, cur_m, cur_d} = date_q;
  assign {ld_y, ld_m, ld_d}    = load_date;

  assign cur_leap  = is_leap(32'(cur_y));
  assign ld_leap   = is_leap(32'(ld_y));
  assign cur_mlen  = month_len(cur_m, cur_leap);
  assign prev_mlen = month_len(cur_m - 4'd1, cur_leap);

  assign at_max = (cur_y == YEAR_MAX) && (cur_m == 4'd12) && (cur_d == 5'd31);
  assign at_min = (cur_y == YEAR_W'(1)) && (cur_m == 4'd1) && (cur_d == 5'd1);

  assign load_ok = (ld_y != '0) && (ld_m >= 4'd1) && (ld_m <= 4'd12) &&
                   (ld_d >= 5'd1) && (ld_d <= month_len(ld_m, ld_leap));
  assign start   = load && load_ok;
  assign fwd     = step_fwd || (tick && run_en);

  weekday_calc_serial #(
    .YEAR_W  (YEAR_W),
    .SUM_W   (SUM_W),
    .LATENCY (LATENCY)
  ) u_calc (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .year_i  (ld_y),
    .month_i (ld_m),
    .day_i   (ld_d),
    .busy_o  (calc_busy),
    .done_o  (calc_done),
    .wday_o  (calc_wday)
  );

  always_comb begin
    date_d = date_q;
    wday_d = wday_q;
    pend_d = pend_q;
    err_d  = 1'b0;
    if (load && !load_ok) err_d = 1'b1;
    // A valid load restarts the calculator; an invalid one leaves it running.
    if (start) begin
      pend_d = load_date;
    end else if (calc_done) begin
      date_d = pend_q;
      wday_d = calc_wday;
    end else if (!load && !calc_busy && (fwd != step_bwd)) begin
      if (fwd) begin
        if (at_max) begin
          err_d = 1'b1;
        end else begin
          wday_d = (wday_q == 3'd6) ? 3'd0 : wday_q + 3'd1;
          if (cur_d < cur_mlen)     date_d = {cur_y, cur_m, cur_d + 5'd1};
          else if (cur_m < 4'd12)   date_d = {cur_y, cur_m + 4'd1, 5'd1};
          else                      date_d = {cur_y + YEAR_W'(1), 4'd1, 5'd1};
        end
      end else begin
        if (at_min) begin
          err_d = 1'b1;
        end else begin
          wday_d = (wday_q == 3'd0) ? 3'd6 : wday_q - 3'd1;
          if (cur_d > 5'd1)         date_d = {cur_y, cur_m, cur_d - 5'd1};
          else if (cur_m > 4'd1)    date_d = {cur_y, cur_m - 4'd1, prev_mlen};
          else                      date_d = {cur_y - YEAR_W'(1), 4'd12, 5'd31};
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      date_q <= RST_DATE;
      wday_q <= 3'd1;
      err_q  <= 1'b0;
    end else begin
      date_q <= date_d;
      wday_q <= wday_d;
      err_q  <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    pend_q <= pend_d;
  end

  assign date    = date_q;
  assign weekday = wday_q;
  assign valid   = !calc_busy;
  assign busy    = calc_busy;
  assign err     = err_q;

endmodule

// File: tb/tb_date_step_controller.sv
// Directed bench for date_step_controller with hand-computed dates and weekdays.
module tb_date_step_controller;

  logic        clk = 1'b0;
  logic        rst, load, step_fwd, step_bwd, run_en, tick;
  logic [22:0] load_date;
  logic [22:0] date;
  logic [2:0]  weekday;
  logic        valid, busy, err;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  always #5 clk = ~clk;

  date_step_controller dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_date (load_date),
    .step_fwd  (step_fwd),
    .step_bwd  (step_bwd),
    .run_en    (run_en),
    .tick      (tick),
    .date      (date),
    .weekday   (weekday),
    .valid     (valid),
    .busy      (busy),
    .err       (err)
  );

  function automatic logic [22:0] mkdate(input int y, input int m, input int d);
    return {y[13:0], m[3:0], d[4:0]};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [22:0] d);
    load = 1'b1;
    load_date = d;
    cyc();
    load = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (busy && n < 100) begin
      cyc();
      n++;
    end
  endtask

  task automatic pulse(input logic f, input logic b);
    step_fwd = f;
    step_bwd = b;
    cyc();
    step_fwd = 1'b0;
    step_bwd = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    vec_cnt++; if (date !== 23'h000221) begin miss_cnt++; $display("FAIL reset_date: got %h want %h", date, 23'h000221); end
    vec_cnt++; if (weekday !== 3'd1) begin miss_cnt++; $display("FAIL reset_wday: got %0d want 1", weekday); end
    vec_cnt++; if (valid !== 1'b1) begin miss_cnt++; $display("FAIL reset_valid: got %b want 1", valid); end
    vec_cnt++; if (busy !== 1'b0) begin miss_cnt++; $display("FAIL reset_busy: got %b want 0", busy); end
    vec_cnt++; if (err !== 1'b0) begin miss_cnt++; $display("FAIL reset_err: got %b want 0", err); end
  endtask

  task automatic test_load_2000();
    int n;
    do_load(mkdate(2000, 1, 1));
    vec_cnt++; if (busy !== 1'b1 || valid !== 1'b0) begin miss_cnt++; $display("FAIL load2000_busy: got busy=%b valid=%b want 1/0", busy, valid); end
    vec_cnt++; if (date !== 23'h000221) begin miss_cnt++; $display("FAIL load2000_hold: got %h want %h", date, 23'h000221); end
    wait_done(n);
    vec_cnt++; if (n !== 39) begin miss_cnt++; $display("FAIL load2000_latency: got %0d want 39", n); end
    vec_cnt++; if (date !== mkdate(2000, 1, 1)) begin miss_cnt++; $display("FAIL load2000_date: got %h want %h", date, mkdate(2000, 1, 1)); end
    vec_cnt++; if (weekday !== 3'd6) begin miss_cnt++; $display("FAIL load2000_wday: got %0d want 6", weekday); end
    vec_cnt++; if (valid !== 1'b1) begin miss_cnt++; $display("FAIL load2000_valid: got %b want 1", valid); end
  endtask

  task automatic test_load_leapday();
    int n;
    do_load(mkdate(2024, 2, 29));
    wait_done(n);
    vec_cnt++; if (n !== 39) begin miss_cnt++; $display("FAIL leapday_latency: got %0d want 39", n); end
    vec_cnt++; if (weekday !== 3'd4) begin miss_cnt++; $display("FAIL leapday_wday: got %0d want 4", weekday); end
  endtask

  task automatic test_invalid_load();
    do_load(mkdate(1900, 2, 29));
    vec_cnt++; if (err !== 1'b1) begin miss_cnt++; $display("FAIL invalid_err: got %b want 1", err); end
    vec_cnt++; if (busy !== 1'b0) begin miss_cnt++; $display("FAIL invalid_busy: got %b want 0", busy); end
    vec_cnt++; if (date !== mkdate(2024, 2, 29)) begin miss_cnt++; $display("FAIL invalid_date: got %h want %h", date, mkdate(2024, 2, 29)); end
    cyc();
    vec_cnt++; if (err !== 1'b0) begin miss_cnt++; $display("FAIL invalid_err_pulse: got %b want 0", err); end
  endtask

  task automatic test_step_fwd_year();
    int n;
    do_load(mkdate(2023, 12, 31));
    wait_done(n);
    vec_cnt++; if (weekday !== 3'd0) begin miss_cnt++; $display("FAIL fwd_pre_wday: got %0d want 0", weekday); end
    pulse(1'b1, 1'b0);
    vec_cnt++; if (date !== mkdate(2024, 1, 1)) begin miss_cnt++; $display("FAIL fwd_year_date: got %h want %h", date, mkdate(2024, 1, 1)); end
    vec_cnt++; if (weekday !== 3'd1) begin miss_cnt++; $display("FAIL fwd_year_wday: got %0d want 1", weekday); end
  endtask

  task automatic test_step_bwd_month();
    int n;
    do_load(mkdate(2024, 3, 1));
    wait_done(n);
    pulse(1'b0, 1'b1);
    vec_cnt++; if (date !== mkdate(2024, 2, 29)) begin miss_cnt++; $display("FAIL bwd_leap_date: got %h want %h", date, mkdate(2024, 2, 29)); end
    vec_cnt++; if (weekday !== 3'd4) begin miss_cnt++; $display("FAIL bwd_leap_wday: got %0d want 4", weekday); end
    do_load(mkdate(2023, 3, 1));
    wait_done(n);
    vec_cnt++; if (weekday !== 3'd3) begin miss_cnt++; $display("FAIL bwd_plain_pre_wday: got %0d want 3", weekday); end
    pulse(1'b0, 1'b1);
    vec_cnt++; if (date !== mkdate(2023, 2, 28)) begin miss_cnt++; $display("FAIL bwd_plain_date: got %h want %h", date, mkdate(2023, 2, 28)); end
    vec_cnt++; if (weekday !== 3'd2) begin miss_cnt++; $display("FAIL bwd_plain_wday: got %0d want 2", weekday); end
  endtask

  task automatic test_boundaries();
    int n;
    do_load(mkdate(1, 1, 1));
    wait_done(n);
    pulse(1'b0, 1'b1);
    vec_cnt++; if (err !== 1'b1) begin miss_cnt++; $display("FAIL low_bound_err: got %b want 1", err); end
    vec_cnt++; if (date !== mkdate(1, 1, 1) || weekday !== 3'd1) begin miss_cnt++; $display("FAIL low_bound_hold: got %h/%0d want %h/1", date, weekday, mkdate(1, 1, 1)); end
    do_load(mkdate(16383, 12, 31));
    wait_done(n);
    pulse(1'b1, 1'b0);
    vec_cnt++; if (err !== 1'b1) begin miss_cnt++; $display("FAIL high_bound_err: got %b want 1", err); end
    vec_cnt++; if (date !== mkdate(16383, 12, 31)) begin miss_cnt++; $display("FAIL high_bound_hold: got %h want %h", date, mkdate(16383, 12, 31)); end
  endtask

  task automatic test_simultaneous();
    int n;
    do_load(mkdate(2023, 3, 1));
    wait_done(n);
    pulse(1'b1, 1'b1);
    vec_cnt++; if (date !== mkdate(2023, 3, 1) || weekday !== 3'd3) begin miss_cnt++; $display("FAIL both_steps_hold: got %h/%0d want %h/3", date, weekday, mkdate(2023, 3, 1)); end
    vec_cnt++; if (err !== 1'b0) begin miss_cnt++; $display("FAIL both_steps_err: got %b want 0", err); end
  endtask

  task automatic test_free_run();
    int n;
    do_load(mkdate(2024, 1, 1));
    wait_done(n);
    tick = 1'b1;
    cyc();
    vec_cnt++; if (date !== mkdate(2024, 1, 1)) begin miss_cnt++; $display("FAIL tick_no_run: got %h want %h", date, mkdate(2024, 1, 1)); end
    run_en = 1'b1;
    repeat (366) cyc();
    tick = 1'b0;
    run_en = 1'b0;
    vec_cnt++; if (date !== mkdate(2025, 1, 1)) begin miss_cnt++; $display("FAIL free_run_date: got %h want %h", date, mkdate(2025, 1, 1)); end
    vec_cnt++; if (weekday !== 3'd3) begin miss_cnt++; $display("FAIL free_run_wday: got %0d want 3", weekday); end
  endtask

  task automatic test_back_to_back();
    int n;
    do_load(mkdate(2000, 1, 1));
    repeat (9) cyc();
    do_load(mkdate(2024, 2, 29));
    wait_done(n);
    vec_cnt++; if (n !== 39) begin miss_cnt++; $display("FAIL reload_latency: got %0d want 39", n); end
    vec_cnt++; if (date !== mkdate(2024, 2, 29) || weekday !== 3'd4) begin miss_cnt++; $display("FAIL reload_result: got %h/%0d want %h/4", date, weekday, mkdate(2024, 2, 29)); end
  endtask

  task automatic test_reset_mid_calc();
    do_load(mkdate(2023, 12, 31));
    repeat (19) cyc();
    vec_cnt++; if (busy !== 1'b1) begin miss_cnt++; $display("FAIL mid_calc_busy: got %b want 1", busy); end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    vec_cnt++; if (date !== 23'h000221 || weekday !== 3'd1) begin miss_cnt++; $display("FAIL mid_rst_date: got %h/%0d want 000221/1", date, weekday); end
    vec_cnt++; if (busy !== 1'b0 || valid !== 1'b1 || err !== 1'b0) begin miss_cnt++; $display("FAIL mid_rst_ctrl: got busy=%b valid=%b err=%b want 0/1/0", busy, valid, err); end
  endtask

  task automatic test_steps_while_busy();
    int n;
    do_load(mkdate(2024, 3, 1));
    step_fwd = 1'b1;
    repeat (5) cyc();
    step_fwd = 1'b0;
    step_bwd = 1'b1;
    repeat (5) cyc();
    step_bwd = 1'b0;
    vec_cnt++; if (date !== 23'h000221 || err !== 1'b0) begin miss_cnt++; $display("FAIL busy_steps_hold: got %h err=%b want 000221 err=0", date, err); end
    wait_done(n);
    vec_cnt++; if (n !== 29) begin miss_cnt++; $display("FAIL busy_steps_latency: got %0d want 29", n); end
    vec_cnt++; if (date !== mkdate(2024, 3, 1) || weekday !== 3'd5) begin miss_cnt++; $display("FAIL busy_steps_result: got %h/%0d want %h/5", date, weekday, mkdate(2024, 3, 1)); end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; load_date = '0;
    step_fwd = 1'b0; step_bwd = 1'b0; run_en = 1'b0; tick = 1'b0;
    test_reset();
    test_load_2000();
    test_load_leapday();
    test_invalid_load();
    test_step_fwd_year();
    test_step_bwd_month();
    test_boundaries();
    test_simultaneous();
    test_free_run();
    test_back_to_back();
    test_reset_mid_calc();
    test_steps_while_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "bench timeout");
  end

endmodule
